output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
// Round-robin, packet-locked arbiter sharing one router output port (block_output) among N_IN input ports.
// - Picks one requesting input, holds the grant until that input's tail flit is written, then rotates priority.
// - Forwards the owner's flits into the output block's FIFO, stalling while that FIFO reports full.
// - Sits between the input buffers' read side and block_output.Data_in/full in each router output path.
// PARAMETERS
// DATA_WIDTH  8    flit width; matches block_output DATA_WIDTH
// N_IN        5    number of requesting input ports (N,E,S,W,Local); legal range 2..8
// OWNER_W     3    width of owner index; must satisfy 2**OWNER_W >= N_IN
// TIMEOUT     15   cycles a locked owner may hold the port with req low before forced release; 1..255
// PORTS
// clk        in   1                 clock; all state changes on rising edge
// rst        in   1                 synchronous, active-high reset
// req        in   N_IN              req[i]=1: input i has a flit ready at data_in slice i
// last       in   N_IN              last[i]=1: current flit of input i is a tail flit (qualified by req[i])
// data_in    in   N_IN*DATA_WIDTH   flit of input i at bits [i*DATA_WIDTH +: DATA_WIDTH]
// full_in    in   1                 output block FIFO full; no write may occur while 1
// grant      out  N_IN              one-hot pop strobe to input i; 1 exactly on cycles its flit is transferred
// data_out   out  DATA_WIDTH        flit to output block Data_in; 0 when write_out=0
// write_out  out  1                 flit transfer strobe into output block
// busy       out  1                 1 while in LOCK state
// owner      out  OWNER_W           index of locked input; 0 when not busy
// timeout    out  1                 one-cycle pulse when a lock is force-released
// BEHAVIOUR
// - Reset (rst=1 at edge): state=IDLE, ptr=0, owner=0, idle counter=0. Outputs grant=0, data_out=0, write_out=0, busy=0, owner=0, timeout=0.
// - States: IDLE, LOCK. The state, ptr, owner, and idle-counter updates are registered. grant, data_out, and write_out are combinational from state/owner/req/full_in.
// - IDLE: no transfers. If any req bit is set, the winner is the first set index scanning ptr, ptr+1, ... mod N_IN.
//   Next cycle: state=LOCK, owner=winner. Arbitration costs exactly 1 cycle.
// - LOCK transfer condition: req[owner]=1 and full_in=0.
//   On transfer: grant[owner]=1, write_out=1, data_out=data_in slice owner, all in the same cycle.
// - Transfer with last[owner]=1 ends the packet. Next state=IDLE, ptr=(owner+1) mod N_IN.
//   A fresh arbitration follows, giving 1 idle bubble between packets.
// - LOCK with full_in=1: no grant and no write. Lock is held and the idle counter is not advanced; backpressure is not a timeout.
// - LOCK with req[owner]=0 and full_in=0: the idle counter increments.
//   Counter reaching TIMEOUT gives next state=IDLE, ptr=(owner+1) mod N_IN, and a 1-cycle timeout pulse.
//   Any transfer clears the counter.
// - Requests from non-owners during LOCK are ignored; there is no preemption.
// - Single-flit packet (req and last together on the first LOCK cycle): one write, then back to IDLE.
// - Index wrap: ptr and owner wrap N_IN-1 -> 0. Indices >= N_IN never appear.
// - rst asserted mid-packet: immediate return to reset values. The partial packet is abandoned; upstream is responsible for flushing it.
// - Invariants: grant is one-hot or zero; write_out == |grant; write_out=0 whenever full_in=1.
// TESTING
// - Reset: hold rst 2 cycles with req=5'b11111 -> all outputs 0, busy=0. First grant after release goes to input 0.
// - Round robin: all req=1, 1-flit packets (last=1) -> write order 0,1,2,3,4,0 with one idle cycle between packets.
// - Lock hold: input 2 sends a 4-flit packet (last on the 4th) while input 3 requests -> exactly 4 consecutive grant[2].
//   data_out = 0xA0..0xA3; input 3 is granted only after that.
// - Backpressure: full_in=1 for 5 cycles mid-packet -> write_out=0 and grant=0 throughout. Lock held, no timeout, transfer resumes when full_in=0.
// - Timeout: owner 1 drops req after its head flit with full_in=0 -> timeout pulses exactly TIMEOUT(15) cycles later.
//   busy=0 next cycle; the next winner is searched from input 2.
// - Mid-packet reset: assert rst during flit 2 of a 4-flit packet -> reset values next cycle. No further grant to the old owner until re-arbitrated from ptr=0.

Source files
------------

// File: rtl/output_port_arbiter.sv
// Round-robin, packet-locked arbiter that shares one router output port among N_IN inputs.
// A winner keeps the port until its tail flit is written or it idles for TIMEOUT cycles.
module output_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_IN       = 5,
  parameter int OWNER_W    = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN-1:0]            req,
  input  logic [N_IN-1:0]            last,
  input  logic [N_IN*DATA_WIDTH-1:0] data_in,
  input  logic                       full_in,
  output logic [N_IN-1:0]            grant,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       write_out,
  output logic                       busy,
  output logic [OWNER_W-1:0]         owner,
  output logic                       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [OWNER_W-1:0] winner;
  logic               found;
  logic [OWNER_W-1:0] next_ptr;
  logic               xfer;
  logic               idle_tick;

  // First requester at or after ptr, wrapping through N_IN-1 back to 0.
  always_comb begin
    int                 idx_int;
    logic [OWNER_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    for (int off = 0; off < N_IN; off++) begin
      idx_int = int'(ptr_q) + off;
      if (idx_int >= N_IN) idx_int = idx_int - N_IN;
      idx = OWNER_W'(idx_int);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign next_ptr  = (owner_q == OWNER_W'(N_IN - 1)) ? '0 : owner_q + 1'b1;
  assign xfer      = (state_q == LOCK) && req[owner_q] && !full_in;
  // A full FIFO is backpressure, not owner inactivity, so it never advances the counter.
  assign idle_tick = (state_q == LOCK) && !req[owner_q] && !full_in;

  assign write_out = xfer;
  assign grant     = xfer ? (N_IN'(1) << owner_q) : '0;
  assign data_out  = xfer ? data_in[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy      = (state_q == LOCK);
  assign owner     = owner_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d = LOCK;
          owner_d = winner;
        end
      end
      LOCK: begin
        if (xfer) begin
          cnt_d = '0;
          if (last[owner_q]) begin
            state_d = IDLE;
            ptr_d   = next_ptr;
            owner_d = '0;
          end
        end else if (idle_tick) begin
          if (cnt_q == 8'(TIMEOUT - 1)) begin
            timeout = 1'b1;
            state_d = IDLE;
            ptr_d   = next_ptr;
            owner_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous and active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: reset, round robin, packet lock, backpressure,
// idle timeout and mid-packet reset, each with hand-computed expectations.
module tb_output_port_arbiter;

  localparam int DW = 8;
  localparam int N  = 5;
  localparam int OW = 3;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] data_in;
  logic            full_in;
  logic [N-1:0]    grant;
  logic [DW-1:0]   data_out;
  logic            write_out;
  logic            busy;
  logic [OW-1:0]   owner;
  logic            timeout;

  int n_cmp = 0;
  int n_err = 0;

  output_port_arbiter #(.DATA_WIDTH(DW), .N_IN(N), .OWNER_W(OW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .data_in   (data_in),
    .full_in   (full_in),
    .grant     (grant),
    .data_out  (data_out),
    .write_out (write_out),
    .busy      (busy),
    .owner     (owner),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle so combinational outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; data_in = '0; full_in = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 5'b11111; last = 5'b11111; data_in = '0; full_in = 1'b0;
    tick();
    tick();
    n_cmp++; if (grant !== 5'b0)     begin n_err++; $display("FAIL reset_grant got=%b exp=%b", grant, 5'b0); end
    n_cmp++; if (write_out !== 1'b0) begin n_err++; $display("FAIL reset_write got=%b exp=0", write_out); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", data_out); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (owner !== 3'd0)     begin n_err++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    n_cmp++; if (timeout !== 1'b0)   begin n_err++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    rst = 1'b0;
    #1;
    n_cmp++; if (grant !== 5'b0) begin n_err++; $display("FAIL reset_arb_cycle got=%b exp=%b", grant, 5'b0); end
    tick();
    n_cmp++; if (grant !== 5'b00001) begin n_err++; $display("FAIL reset_first_grant got=%b exp=%b", grant, 5'b00001); end
    n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL reset_first_busy got=%b exp=1", busy); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    req = 5'b11111; last = 5'b11111;
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = 8'(8'h10 + i);
    for (int p = 0; p < 6; p++) begin
      #1;
      n_cmp++; if (grant !== 5'b0) begin n_err++; $display("FAIL rr_bubble p=%0d got=%b exp=%b", p, grant, 5'b0); end
      tick();
      exp_g = 5'b00001 << (p % N);
      n_cmp++; if (grant !== exp_g)                begin n_err++; $display("FAIL rr_grant p=%0d got=%b exp=%b", p, grant, exp_g); end
      n_cmp++; if (data_out !== 8'(8'h10 + p % N)) begin n_err++; $display("FAIL rr_data p=%0d got=%h exp=%h", p, data_out, 8'(8'h10 + p % N)); end
      n_cmp++; if (owner !== 3'(p % N))            begin n_err++; $display("FAIL rr_owner p=%0d got=%0d exp=%0d", p, owner, p % N); end
      n_cmp++; if (write_out !== 1'b1)             begin n_err++; $display("FAIL rr_write p=%0d got=%b exp=1", p, write_out); end
      tick();
    end
    req = '0; last = '0;
  endtask

  task automatic test_lock_hold();
    do_reset();
    req = 5'b01100; last = 5'b01000;
    data_in[2*DW +: DW] = 8'hA0;
    data_in[3*DW +: DW] = 8'h33;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lock_arb_busy got=%b exp=0", busy); end
    tick();
    for (int k = 0; k < 4; k++) begin
      data_in[2*DW +: DW] = 8'(8'hA0 + k);
      last[2] = (k == 3);
      #1;
      n_cmp++; if (grant !== 5'b00100)       begin n_err++; $display("FAIL lock_grant k=%0d got=%b exp=%b", k, grant, 5'b00100); end
      n_cmp++; if (data_out !== 8'(8'hA0 + k)) begin n_err++; $display("FAIL lock_data k=%0d got=%h exp=%h", k, data_out, 8'(8'hA0 + k)); end
      n_cmp++; if (owner !== 3'd2)           begin n_err++; $display("FAIL lock_owner k=%0d got=%0d exp=2", k, owner); end
      tick();
    end
    req = 5'b01000; last = 5'b01000;
    #1;
    n_cmp++; if (grant !== 5'b0) begin n_err++; $display("FAIL lock_bubble got=%b exp=%b", grant, 5'b0); end
    tick();
    n_cmp++; if (grant !== 5'b01000) begin n_err++; $display("FAIL lock_next_grant got=%b exp=%b", grant, 5'b01000); end
    n_cmp++; if (data_out !== 8'h33) begin n_err++; $display("FAIL lock_next_data got=%h exp=33", data_out); end
    tick();
    req = '0; last = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 5'b00001; last = 5'b0;
    data_in[0 +: DW] = 8'hB0;
    tick();
    n_cmp++; if (grant !== 5'b00001) begin n_err++; $display("FAIL bp_head_grant got=%b exp=%b", grant, 5'b00001); end
    n_cmp++; if (data_out !== 8'hB0) begin n_err++; $display("FAIL bp_head_data got=%h exp=B0", data_out); end
    tick();
    data_in[0 +: DW] = 8'hB1;
    full_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (grant !== 5'b0)     begin n_err++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, grant, 5'b0); end
      n_cmp++; if (write_out !== 1'b0) begin n_err++; $display("FAIL bp_write c=%0d got=%b exp=0", c, write_out); end
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL bp_data c=%0d got=%h exp=00", c, data_out); end
      n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL bp_busy c=%0d got=%b exp=1", c, busy); end
      n_cmp++; if (timeout !== 1'b0)   begin n_err++; $display("FAIL bp_timeout c=%0d got=%b exp=0", c, timeout); end
      tick();
    end
    full_in = 1'b0; last = 5'b00001;
    #1;
    n_cmp++; if (grant !== 5'b00001) begin n_err++; $display("FAIL bp_resume_grant got=%b exp=%b", grant, 5'b00001); end
    n_cmp++; if (data_out !== 8'hB1) begin n_err++; $display("FAIL bp_resume_data got=%h exp=B1", data_out); end
    tick();
    req = '0; last = '0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 5'b00010; last = 5'b0;
    data_in[1*DW +: DW] = 8'hC0;
    tick();
    n_cmp++; if (grant !== 5'b00010) begin n_err++; $display("FAIL to_head_grant got=%b exp=%b", grant, 5'b00010); end
    tick();
    // Owner goes quiet while input 3 requests; the lock must not be preempted.
    req = 5'b01000;
    for (int j = 1; j <= TO; j++) begin
      #1;
      n_cmp++; if (timeout !== (j == TO)) begin n_err++; $display("FAIL to_pulse j=%0d got=%b exp=%b", j, timeout, (j == TO)); end
      n_cmp++; if (grant !== 5'b0)        begin n_err++; $display("FAIL to_grant j=%0d got=%b exp=%b", j, grant, 5'b0); end
      n_cmp++; if (busy !== 1'b1)         begin n_err++; $display("FAIL to_busy j=%0d got=%b exp=1", j, busy); end
      tick();
    end
    req = 5'b11111; last = 5'b11111;
    #1;
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL to_after_busy got=%b exp=0", busy); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_after_pulse got=%b exp=0", timeout); end
    tick();
    n_cmp++; if (grant !== 5'b00100) begin n_err++; $display("FAIL to_next_winner got=%b exp=%b", grant, 5'b00100); end
    tick();
    req = '0; last = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 5'b01000; last = 5'b0;
    data_in[3*DW +: DW] = 8'hD0;
    tick();
    n_cmp++; if (grant !== 5'b01000) begin n_err++; $display("FAIL mr_flit1_grant got=%b exp=%b", grant, 5'b01000); end
    tick();
    data_in[3*DW +: DW] = 8'hD1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 5'b01001;
    #1;
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL mr_busy got=%b exp=0", busy); end
    n_cmp++; if (grant !== 5'b0) begin n_err++; $display("FAIL mr_grant got=%b exp=%b", grant, 5'b0); end
    n_cmp++; if (owner !== 3'd0) begin n_err++; $display("FAIL mr_owner got=%0d exp=0", owner); end
    tick();
    n_cmp++; if (grant !== 5'b00001) begin n_err++; $display("FAIL mr_rearb_grant got=%b exp=%b", grant, 5'b00001); end
    tick();
    req = '0; last = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; last = '0; data_in = '0; full_in = 1'b0;
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
